// File: rtl/axi_arb_pkg.sv
// Shared types and AXI3 field widths for the 2x1 AXI arbiter.
package axi_arb_pkg;

   localparam int unsigned LEN_W   = 4;
   localparam int unsigned SIZE_W  = 3;
   localparam int unsigned BURST_W = 2;
   localparam int unsigned LOCK_W  = 2;
   localparam int unsigned CACHE_W = 4;
   localparam int unsigned PROT_W  = 3;
   localparam int unsigned RESP_W  = 2;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_ADDR = 2'd1,
      WR_DATA = 2'd2,
      WR_RESP = 2'd3
   } wr_state_t;

endpackage

// File: rtl/axi_arb_gnt2.sv
// Two-request grant picker (gnt_c = 1 selects requester 1). Fixed s1-over-s0
// priority by default; round-robin when AXI_ARB_ROUND_ROBIN_EN is defined.
module axi_arb_gnt2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       upd,
   output logic       gnt_c
);

`ifdef AXI_ARB_ROUND_ROBIN_EN
   logic ptr_q;
   logic ptr_d;

   // ptr_q remembers the last winner; on a conflict the other requester wins.
   always_comb begin
      gnt_c = req[1];
      if (req == 2'b11) gnt_c = ~ptr_q;
      ptr_d = ptr_q;
      if (upd) ptr_d = gnt_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end
`else
   logic unused_sig;
   assign unused_sig = ^{clk, rst_n, upd, req[0]};
   assign gnt_c      = req[1];
`endif

endmodule

// File: rtl/axi_arbiter_2x1.sv
// Two-master to one-slave AXI3 arbiter with independent read/write FSMs.
// Optional round-robin arbitration: define AXI_ARB_ROUND_ROBIN_EN.
module axi_arbiter_2x1
   import axi_arb_pkg::*;
#(
   parameter int unsigned ID_W   = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   // master 0 (icache)
   input  logic [ID_W-1:0]       s0_arid,
   input  logic [ADDR_W-1:0]     s0_araddr,
   input  logic [LEN_W-1:0]      s0_arlen,
   input  logic [SIZE_W-1:0]     s0_arsize,
   input  logic [BURST_W-1:0]    s0_arburst,
   input  logic [LOCK_W-1:0]     s0_arlock,
   input  logic [CACHE_W-1:0]    s0_arcache,
   input  logic [PROT_W-1:0]     s0_arprot,
   input  logic                  s0_arvalid,
   output logic                  s0_arready,
   output logic [ID_W-1:0]       s0_rid,
   output logic [DATA_W-1:0]     s0_rdata,
   output logic [RESP_W-1:0]     s0_rresp,
   output logic                  s0_rlast,
   output logic                  s0_rvalid,
   input  logic                  s0_rready,
   input  logic [ID_W-1:0]       s0_awid,
   input  logic [ADDR_W-1:0]     s0_awaddr,
   input  logic [LEN_W-1:0]      s0_awlen,
   input  logic [SIZE_W-1:0]     s0_awsize,
   input  logic [BURST_W-1:0]    s0_awburst,
   input  logic [LOCK_W-1:0]     s0_awlock,
   input  logic [CACHE_W-1:0]    s0_awcache,
   input  logic [PROT_W-1:0]     s0_awprot,
   input  logic                  s0_awvalid,
   output logic                  s0_awready,
   input  logic [ID_W-1:0]       s0_wid,
   input  logic [DATA_W-1:0]     s0_wdata,
   input  logic [DATA_W/8-1:0]   s0_wstrb,
   input  logic                  s0_wlast,
   input  logic                  s0_wvalid,
   output logic                  s0_wready,
   output logic [ID_W-1:0]       s0_bid,
   output logic [RESP_W-1:0]     s0_bresp,
   output logic                  s0_bvalid,
   input  logic                  s0_bready,
   // master 1 (dcache)
   input  logic [ID_W-1:0]       s1_arid,
   input  logic [ADDR_W-1:0]     s1_araddr,
   input  logic [LEN_W-1:0]      s1_arlen,
   input  logic [SIZE_W-1:0]     s1_arsize,
   input  logic [BURST_W-1:0]    s1_arburst,
   input  logic [LOCK_W-1:0]     s1_arlock,
   input  logic [CACHE_W-1:0]    s1_arcache,
   input  logic [PROT_W-1:0]     s1_arprot,
   input  logic                  s1_arvalid,
   output logic                  s1_arready,
   output logic [ID_W-1:0]       s1_rid,
   output logic [DATA_W-1:0]     s1_rdata,
   output logic [RESP_W-1:0]     s1_rresp,
   output logic                  s1_rlast,
   output logic                  s1_rvalid,
   input  logic                  s1_rready,
   input  logic [ID_W-1:0]       s1_awid,
   input  logic [ADDR_W-1:0]     s1_awaddr,
   input  logic [LEN_W-1:0]      s1_awlen,
   input  logic [SIZE_W-1:0]     s1_awsize,
   input  logic [BURST_W-1:0]    s1_awburst,
   input  logic [LOCK_W-1:0]     s1_awlock,
   input  logic [CACHE_W-1:0]    s1_awcache,
   input  logic [PROT_W-1:0]     s1_awprot,
   input  logic                  s1_awvalid,
   output logic                  s1_awready,
   input  logic [ID_W-1:0]       s1_wid,
   input  logic [DATA_W-1:0]     s1_wdata,
   input  logic [DATA_W/8-1:0]   s1_wstrb,
   input  logic                  s1_wlast,
   input  logic                  s1_wvalid,
   output logic                  s1_wready,
   output logic [ID_W-1:0]       s1_bid,
   output logic [RESP_W-1:0]     s1_bresp,
   output logic                  s1_bvalid,
   input  logic                  s1_bready,
   // slave side
   output logic [ID_W-1:0]       m_arid,
   output logic [ADDR_W-1:0]     m_araddr,
   output logic [LEN_W-1:0]      m_arlen,
   output logic [SIZE_W-1:0]     m_arsize,
   output logic [BURST_W-1:0]    m_arburst,
   output logic [LOCK_W-1:0]     m_arlock,
   output logic [CACHE_W-1:0]    m_arcache,
   output logic [PROT_W-1:0]     m_arprot,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [ID_W-1:0]       m_rid,
   input  logic [DATA_W-1:0]     m_rdata,
   input  logic [RESP_W-1:0]     m_rresp,
   input  logic                  m_rlast,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   output logic [ID_W-1:0]       m_awid,
   output logic [ADDR_W-1:0]     m_awaddr,
   output logic [LEN_W-1:0]      m_awlen,
   output logic [SIZE_W-1:0]     m_awsize,
   output logic [BURST_W-1:0]    m_awburst,
   output logic [LOCK_W-1:0]     m_awlock,
   output logic [CACHE_W-1:0]    m_awcache,
   output logic [PROT_W-1:0]     m_awprot,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [ID_W-1:0]       m_wid,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [DATA_W/8-1:0]   m_wstrb,
   output logic                  m_wlast,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [ID_W-1:0]       m_bid,
   input  logic [RESP_W-1:0]     m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready
);

   rd_state_t rd_state_q, rd_state_d;
   wr_state_t wr_state_q, wr_state_d;
   logic      rd_gnt_q, rd_gnt_d;
   logic      wr_gnt_q, wr_gnt_d;
   logic      rd_upd_c, wr_upd_c;
   logic      rd_win_c, wr_win_c;

   axi_arb_gnt2 u_rd_gnt (
      .clk   (aclk),
      .rst_n (aresetn),
      .req   ({s1_arvalid, s0_arvalid}),
      .upd   (rd_upd_c),
      .gnt_c (rd_win_c)
   );

   axi_arb_gnt2 u_wr_gnt (
      .clk   (aclk),
      .rst_n (aresetn),
      .req   ({s1_awvalid, s0_awvalid}),
      .upd   (wr_upd_c),
      .gnt_c (wr_win_c)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_state_q <= RD_IDLE;
         wr_state_q <= WR_IDLE;
         rd_gnt_q   <= 1'b0;
         wr_gnt_q   <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         wr_state_q <= wr_state_d;
         rd_gnt_q   <= rd_gnt_d;
         wr_gnt_q   <= wr_gnt_d;
      end
   end

   // Read path: address phase then data beats until rlast.
   always_comb begin
      rd_state_d = rd_state_q;
      rd_gnt_d   = rd_gnt_q;
      rd_upd_c   = 1'b0;
      m_arvalid  = 1'b0;
      m_rready   = 1'b0;
      s0_arready = 1'b0;
      s1_arready = 1'b0;
      s0_rvalid  = 1'b0;
      s1_rvalid  = 1'b0;
      unique case (rd_state_q)
         RD_IDLE: begin
            if (s0_arvalid || s1_arvalid) begin
               rd_upd_c   = 1'b1;
               rd_gnt_d   = rd_win_c;
               rd_state_d = RD_ADDR;
            end
         end
         RD_ADDR: begin
            m_arvalid  = rd_gnt_q ? s1_arvalid : s0_arvalid;
            s0_arready = ~rd_gnt_q & m_arready;
            s1_arready = rd_gnt_q & m_arready;
            if (m_arvalid && m_arready) rd_state_d = RD_DATA;
         end
         RD_DATA: begin
            m_rready  = rd_gnt_q ? s1_rready : s0_rready;
            s0_rvalid = ~rd_gnt_q & m_rvalid;
            s1_rvalid = rd_gnt_q & m_rvalid;
            if (m_rvalid && m_rready && m_rlast) rd_state_d = RD_IDLE;
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // Write path: address, data beats until wlast, then the B response.
   always_comb begin
      wr_state_d = wr_state_q;
      wr_gnt_d   = wr_gnt_q;
      wr_upd_c   = 1'b0;
      m_awvalid  = 1'b0;
      m_wvalid   = 1'b0;
      m_bready   = 1'b0;
      s0_awready = 1'b0;
      s1_awready = 1'b0;
      s0_wready  = 1'b0;
      s1_wready  = 1'b0;
      s0_bvalid  = 1'b0;
      s1_bvalid  = 1'b0;
      unique case (wr_state_q)
         WR_IDLE: begin
            if (s0_awvalid || s1_awvalid) begin
               wr_upd_c   = 1'b1;
               wr_gnt_d   = wr_win_c;
               wr_state_d = WR_ADDR;
            end
         end
         WR_ADDR: begin
            m_awvalid  = wr_gnt_q ? s1_awvalid : s0_awvalid;
            s0_awready = ~wr_gnt_q & m_awready;
            s1_awready = wr_gnt_q & m_awready;
            if (m_awvalid && m_awready) wr_state_d = WR_DATA;
         end
         WR_DATA: begin
            m_wvalid  = wr_gnt_q ? s1_wvalid : s0_wvalid;
            s0_wready = ~wr_gnt_q & m_wready;
            s1_wready = wr_gnt_q & m_wready;
            if (m_wvalid && m_wready && m_wlast) wr_state_d = WR_RESP;
         end
         WR_RESP: begin
            m_bready  = wr_gnt_q ? s1_bready : s0_bready;
            s0_bvalid = ~wr_gnt_q & m_bvalid;
            s1_bvalid = wr_gnt_q & m_bvalid;
            if (m_bvalid && m_bready) wr_state_d = WR_IDLE;
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   // Payload steering follows the latched grants; nothing here is registered.
   assign m_arid    = rd_gnt_q ? s1_arid    : s0_arid;
   assign m_araddr  = rd_gnt_q ? s1_araddr  : s0_araddr;
   assign m_arlen   = rd_gnt_q ? s1_arlen   : s0_arlen;
   assign m_arsize  = rd_gnt_q ? s1_arsize  : s0_arsize;
   assign m_arburst = rd_gnt_q ? s1_arburst : s0_arburst;
   assign m_arlock  = rd_gnt_q ? s1_arlock  : s0_arlock;
   assign m_arcache = rd_gnt_q ? s1_arcache : s0_arcache;
   assign m_arprot  = rd_gnt_q ? s1_arprot  : s0_arprot;

   assign m_awid    = wr_gnt_q ? s1_awid    : s0_awid;
   assign m_awaddr  = wr_gnt_q ? s1_awaddr  : s0_awaddr;
   assign m_awlen   = wr_gnt_q ? s1_awlen   : s0_awlen;
   assign m_awsize  = wr_gnt_q ? s1_awsize  : s0_awsize;
   assign m_awburst = wr_gnt_q ? s1_awburst : s0_awburst;
   assign m_awlock  = wr_gnt_q ? s1_awlock  : s0_awlock;
   assign m_awcache = wr_gnt_q ? s1_awcache : s0_awcache;
   assign m_awprot  = wr_gnt_q ? s1_awprot  : s0_awprot;

   assign m_wid     = wr_gnt_q ? s1_wid     : s0_wid;
   assign m_wdata   = wr_gnt_q ? s1_wdata   : s0_wdata;
   assign m_wstrb   = wr_gnt_q ? s1_wstrb   : s0_wstrb;
   assign m_wlast   = wr_gnt_q ? s1_wlast   : s0_wlast;

   assign s0_rid    = m_rid;
   assign s0_rdata  = m_rdata;
   assign s0_rresp  = m_rresp;
   assign s0_rlast  = m_rlast;
   assign s1_rid    = m_rid;
   assign s1_rdata  = m_rdata;
   assign s1_rresp  = m_rresp;
   assign s1_rlast  = m_rlast;

   assign s0_bid    = m_bid;
   assign s0_bresp  = m_bresp;
   assign s1_bid    = m_bid;
   assign s1_bresp  = m_bresp;

endmodule

// File: doc/axi_arbiter_2x1.md
# axi_arbiter_2x1

Two-master to one-slave AXI3 arbiter that shares the CPU's single external AXI port between the instruction-side and data-side `cache_to_axi` bridges inside `mycpu_top`. It serialises read bursts and write bursts independently, with at most one outstanding read and one outstanding write. Responses are routed back by a latched grant, not by ID. It replaces the vendor 2x1 crossbar with a small, verifiable FSM-based block.

## Interface
- ID_W, 4, AXI ID width (passed through unchanged).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; WSTRB width is DATA_W/8.
- aclk  in  1  sole clock; all logic is rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- s0_ar{id,addr,len,size,burst,lock,cache,prot,valid} in / s0_arready out: icache AR, AXI3 widths (4, ADDR_W, 4, 3, 2, 2, 4, 3, 1).
- s0_r{id,data,resp,last,valid} out / s0_rready in: icache R.
- s0_aw{id,addr,len,size,burst,lock,cache,prot,valid} in / s0_awready out: icache AW.
- s0_w{id,data,strb,last,valid} in / s0_wready out: icache W.
- s0_b{id,resp,valid} out / s0_bready in: icache B.
- s1_*: identical bundle for dcache.
- m_*: mirrored bundle toward the external slave. Its outputs connect to the top-level ar*/aw*/w* ports and the *ready ports of r/b; its inputs come from the slave.

## Operation
- The read path and the write path are separate FSMs. They run concurrently and never stall each other.
- Read FSM states:
  - RD_IDLE: if s0_arvalid or s1_arvalid is high, latch rd_gnt and go to RD_ADDR. Otherwise stay.
  - RD_ADDR: m_ar* = s[rd_gnt]_ar*. s[rd_gnt]_arready = m_arready. On m_arvalid&m_arready, go to RD_DATA.
  - RD_DATA: s[rd_gnt]_r* = m_r*. m_rready = s[rd_gnt]_rready. On m_rvalid&m_rready&m_rlast, go to RD_IDLE.
- Write FSM states:
  - WR_IDLE: arbitrate on awvalid and latch wr_gnt.
  - WR_ADDR: forward AW. On handshake, go to WR_DATA.
  - WR_DATA: forward W. On a handshake with wlast, go to WR_RESP.
  - WR_RESP: forward B. On bvalid&bready, go to WR_IDLE.
- The non-granted master always sees arready/awready/wready/rvalid/bvalid = 0. A master may raise wvalid before its AW is accepted; W is blocked (wready = 0) until WR_DATA.
- All m_* payload fields are multiplexed from the latched grant. No payload is registered.
- m_arvalid is 0 outside RD_ADDR. m_awvalid is 0 outside WR_ADDR. m_wvalid is 0 outside WR_DATA. m_rready is 0 outside RD_DATA. m_bready is 0 outside WR_RESP.
- The grant is held for the entire burst, regardless of arlen/awlen (0–15 beats).

## Timing
- Arbitration latency: 1 cycle. A valid seen in IDLE at edge N is presented on m_*valid from cycle N+1.
- After the last R beat, or after the B handshake, the FSM is back in IDLE the next cycle. The minimum gap between back-to-back bursts is 1 idle cycle.
- Simultaneous requests in IDLE resolve per the Configuration section. A request arriving while busy waits. The master must hold valid stable, per AXI.
- Reset values: every *valid and *ready output is 0; both FSMs are in IDLE; the RR pointers point to s0; the grants are 0. Payload outputs follow the s0 mux.
- Deasserting aresetn mid-burst forces IDLE immediately and asynchronously and drops all valids and readies. Recovering the slave is the system's responsibility.
- An m_rvalid arriving outside RD_DATA is not accepted (rready = 0). A stray m_bvalid is handled the same way.

## Configuration
- AXI_ARB_ROUND_ROBIN_EN defined: each FSM keeps a 1-bit last-granted pointer. On a conflict, the master not granted last wins. The pointer updates on every grant.
- Not defined: fixed priority, s1 (dcache) over s0. No pointer register exists.

## Structure
- Package axi_arb_pkg holds:
  - rd_state_t and wr_state_t enums.
  - AXI3 field width constants: LEN_W = 4, SIZE_W = 3, BURST_W = 2, LOCK_W = 2, CACHE_W = 4, PROT_W = 3, RESP_W = 2.
- Sub-module axi_arb_gnt2: 2-request grant logic, including the optional RR pointer. It takes req[1:0] and an update strobe and produces gnt. It is instantiated once for read and once for write.

## Test plan
- s0 arvalid alone, araddr = 0xBFC0_0000, arlen = 7 -> m_araddr = 0xBFC0_0000 one cycle later. All 8 beats are routed only to s0; s1_rvalid stays 0. RD_IDLE is reached the cycle after the rlast handshake.
- s0 and s1 raise arvalid in the same cycle, with RR off -> s1 is served first, then s0. With RR on and last grant = s1 -> s0 first.
- s1 write: awaddr = 0x8000_1000, awlen = 3, wvalid asserted before AW -> s1_wready = 0 until the AW handshake. 4 beats pass through, then B (bresp = 0) is returned to s1 only.
- Concurrent s0 read burst and s1 write burst -> both complete with no cross-stall. Beat counts match the arlen/awlen values.
- m_rready toggled by s0_rready back-pressure with rvalid held -> no beat is lost or duplicated.
- aresetn pulled low during RD_DATA beat 2 -> all valids and readies are 0 that cycle. After release, a new s1 request is granted normally.
